score_traceback: RTL and testbench

SCORE_TRACEBACK -- requirements
Module: score_traceback

---
 rtl/score_traceback.sv | 248 ++++++++++++++++++++++++
 tb/tb_score_traceback.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_traceback.sv
// Score-matrix traceback engine: walks from (len_i,len_j) back to (0,0),
// reading four scores per interior cell from an external score RAM and
// emitting one direction strobe per step. Matrix inconsistencies raise a
// sticky err flag but the walk always completes.
module score_traceback #(
  parameter int N           = 128,
  parameter int BitAddr     = $clog2(N+1),
  parameter int addr_lenght = $clog2((N+1)*(N+1)),
  parameter int MATCH       = 1,
  parameter int MISMATCH    = -1,
  parameter int GAP         = -2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BitAddr:0]       len_i,
  input  logic [BitAddr:0]       len_j,
  output logic                   ram_en,
  output logic [addr_lenght-1:0] ram_addr,
  input  logic signed [8:0]      ram_data,
  output logic [BitAddr:0]       i_out,
  output logic [BitAddr:0]       j_out,
  input  logic                   match,
  output logic                   step_valid,
  output logic [1:0]             step_dir,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int CW = BitAddr + 1;
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;

  typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, EDGE, FIN} state_t;

  // Where to go after the coordinates change: finished, border walk, or a RAM read.
  function automatic state_t route(input logic [CW-1:0] i, input logic [CW-1:0] j);
    if (i == ZERO_C && j == ZERO_C) begin
      return FIN;
    end else if (i == ZERO_C || j == ZERO_C) begin
      return EDGE;
    end else begin
      return READ;
    end
  endfunction

  // Row-major score-RAM address of cell (i,j).
  function automatic logic [addr_lenght-1:0] cell_addr(input logic [CW-1:0] i,
                                                        input logic [CW-1:0] j);
    return addr_lenght'(i) * addr_lenght'(N + 1) + addr_lenght'(j);
  endfunction

  // Widen a 9-bit score to 10 bits so sums never wrap.
  function automatic logic [9:0] sext10(input logic [8:0] v);
    return {v[8], v};
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [CW-1:0]          i_q, i_d, j_q, j_d;
  logic [8:0]             c_q, c_d, d_q, d_d, u_q, u_d, l_q, l_d;
  logic                   ram_en_q, ram_en_d;
  logic [addr_lenght-1:0] ram_addr_q, ram_addr_d;
  logic                   step_valid_q, step_valid_d;
  logic [1:0]             step_dir_q, step_dir_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [9:0] diag_score_s;
  logic       diag_ok_s, up_ok_s, left_ok_s, eval_bad_s;
  logic [1:0] eval_dir_s;

  assign diag_score_s = match ? 10'(MATCH) : 10'(MISMATCH);
  assign diag_ok_s    = (sext10(c_q) == sext10(d_q) + diag_score_s);
  assign up_ok_s      = (sext10(c_q) == sext10(u_q) + 10'(GAP));
  assign left_ok_s    = (sext10(c_q) == sext10(l_q) + 10'(GAP));
  assign eval_bad_s   = ~(diag_ok_s | up_ok_s | left_ok_s);

  // Step decision with priority diag > up > left; inconsistent cells fall back to diag.
  always_comb begin
    eval_dir_s = DIR_DIAG;
    if (diag_ok_s) begin
      eval_dir_s = DIR_DIAG;
    end else if (up_ok_s) begin
      eval_dir_s = DIR_UP;
    end else if (left_ok_s) begin
      eval_dir_s = DIR_LEFT;
    end else begin
      eval_dir_s = DIR_DIAG;
    end
  end

  // Next-state, datapath and output computation for the traceback FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    i_d          = i_q;
    j_d          = j_q;
    c_d          = c_q;
    d_d          = d_q;
    u_d          = u_q;
    l_d          = l_q;
    ram_en_d     = 1'b0;
    ram_addr_d   = {addr_lenght{1'b0}};
    step_valid_d = 1'b0;
    step_dir_d   = step_dir_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = len_i;
          j_d     = len_j;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 2'd0;
          state_d = route(len_i, len_j);
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Data arriving now belongs to the address issued one cycle earlier.
        case (cnt_q)
          2'd1:    c_d = ram_data;
          2'd2:    d_d = ram_data;
          2'd3:    u_d = ram_data;
          default: c_d = c_q;
        endcase
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = WAIT;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      WAIT: begin
        l_d     = ram_data;
        state_d = EVAL;
      end
      EVAL: begin
        step_valid_d = 1'b1;
        step_dir_d   = eval_dir_s;
        err_d        = err_q | eval_bad_s;
        case (eval_dir_s)
          DIR_UP:   i_d = i_q - ONE_C;
          DIR_LEFT: j_d = j_q - ONE_C;
          default: begin
            i_d = i_q - ONE_C;
            j_d = j_q - ONE_C;
          end
        endcase
        cnt_d   = 2'd0;
        state_d = route(i_d, j_d);
      end
      EDGE: begin
        step_valid_d = 1'b1;
        if (j_q == ZERO_C) begin
          step_dir_d = DIR_UP;
          i_d        = i_q - ONE_C;
        end else begin
          step_dir_d = DIR_LEFT;
          j_d        = j_q - ONE_C;
        end
        cnt_d   = 2'd0;
        state_d = route(i_d, j_d);
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // RAM port is driven one cycle ahead so ram_en is high exactly in READ.
    if (state_d == READ) begin
      ram_en_d = 1'b1;
      case (cnt_d)
        2'd0:    ram_addr_d = cell_addr(i_d, j_d);
        2'd1:    ram_addr_d = cell_addr(i_d - ONE_C, j_d - ONE_C);
        2'd2:    ram_addr_d = cell_addr(i_d - ONE_C, j_d);
        default: ram_addr_d = cell_addr(i_d, j_d - ONE_C);
      endcase
    end else begin
      ram_en_d   = 1'b0;
      ram_addr_d = {addr_lenght{1'b0}};
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      i_q          <= ZERO_C;
      j_q          <= ZERO_C;
      c_q          <= 9'd0;
      d_q          <= 9'd0;
      u_q          <= 9'd0;
      l_q          <= 9'd0;
      ram_en_q     <= 1'b0;
      ram_addr_q   <= {addr_lenght{1'b0}};
      step_valid_q <= 1'b0;
      step_dir_q   <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      i_q          <= i_d;
      j_q          <= j_d;
      c_q          <= c_d;
      d_q          <= d_d;
      u_q          <= u_d;
      l_q          <= l_d;
      ram_en_q     <= ram_en_d;
      ram_addr_q   <= ram_addr_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_addr   = ram_addr_q;
  assign i_out      = i_q;
  assign j_out      = j_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_score_traceback.sv
// Self-checking bench for score_traceback (N=4): directed corner cases plus
// randomized matrices, checked by a scoreboard fed from a traceback model.
module tb_score_traceback;

  localparam int N       = 4;
  localparam int NP      = N + 1;
  localparam int MATCH_S = 1;
  localparam int MISM_S  = -1;
  localparam int GAP_S   = -2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len_i, len_j;
  logic        ram_en;
  logic [4:0]  ram_addr;
  logic signed [8:0] ram_data = 9'sd0;
  logic [3:0]  i_out, j_out;
  logic        match;
  logic        step_valid;
  logic [1:0]  step_dir;
  logic        busy, done, err;

  score_traceback #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .len_i(len_i), .len_j(len_j),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data),
    .i_out(i_out), .j_out(j_out), .match(match),
    .step_valid(step_valid), .step_dir(step_dir),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] mem [0:31];
  int seq_a [0:15];
  int seq_b [0:15];
  int nw [0:4][0:4];

  // Score RAM: one-cycle read latency.
  always @(posedge clk) if (ram_en) ram_data <= mem[ram_addr];

  assign match = (i_out != 4'd0 && j_out != 4'd0) ? (seq_a[i_out] == seq_b[j_out]) : 1'b0;

  typedef struct {int dir; int i; int j; int t;} step_e;
  typedef struct {int e; int t;} done_e;
  step_e sq[$];
  done_e dq[$];
  int    aq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sv(input int i, input int j);
    return int'($signed(mem[i*NP+j]));
  endfunction

  // Reference traceback: walk the stored matrix, queue expected reads, steps and done.
  task automatic run_model(input int li, input int lj, input int k, output int dt, output int ee);
    int i, j, t, c, d, u, l, s, dir;
    int e;
    step_e st;
    done_e de;
    i = li; j = lj; t = k; e = 0;
    while (i != 0 || j != 0) begin
      if (i == 0 || j == 0) begin
        if (j == 0) begin dir = 1; i--; end
        else begin dir = 2; j--; end
        t += 1;
      end else begin
        aq.push_back(i*NP + j);
        aq.push_back((i-1)*NP + j - 1);
        aq.push_back((i-1)*NP + j);
        aq.push_back(i*NP + j - 1);
        c = sv(i, j); d = sv(i-1, j-1); u = sv(i-1, j); l = sv(i, j-1);
        s = (seq_a[i] == seq_b[j]) ? MATCH_S : MISM_S;
        if (c == d + s) dir = 0;
        else if (c == u + GAP_S) dir = 1;
        else if (c == l + GAP_S) dir = 2;
        else begin dir = 0; e = 1; end
        if (dir == 0) begin i--; j--; end
        else if (dir == 1) i--;
        else j--;
        t += 6;
      end
      st.dir = dir; st.i = i; st.j = j; st.t = t;
      sq.push_back(st);
    end
    de.e = e; de.t = t + 1;
    dq.push_back(de);
    dt = t + 1;
    ee = e;
  endtask

  // Fill mem with a consistent alignment matrix of random sequences, optionally corrupting one cell.
  task automatic build(input bit corrupt);
    int s, best;
    for (int i = 1; i <= N; i++) seq_a[i] = int'($urandom_range(0, 1));
    for (int j = 1; j <= N; j++) seq_b[j] = int'($urandom_range(0, 1));
    for (int i = 0; i <= N; i++) nw[i][0] = i * GAP_S;
    for (int j = 0; j <= N; j++) nw[0][j] = j * GAP_S;
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++) begin
        s = (seq_a[i] == seq_b[j]) ? MATCH_S : MISM_S;
        best = nw[i-1][j-1] + s;
        if (nw[i-1][j] + GAP_S > best) best = nw[i-1][j] + GAP_S;
        if (nw[i][j-1] + GAP_S > best) best = nw[i][j-1] + GAP_S;
        nw[i][j] = best;
      end
    for (int i = 0; i <= N; i++)
      for (int j = 0; j <= N; j++) mem[i*NP+j] = 9'(nw[i][j]);
    if (corrupt) mem[$urandom_range(1, N)*NP + $urandom_range(1, N)] = 9'($urandom_range(0, 511));
  endtask

  // Issue one traceback, optionally poking start while busy and in FIN, then verify completion.
  task automatic do_op(input int li, input int lj, input bit poke);
    int dt, ee, k;
    @(negedge clk);
    run_model(li, lj, cyc + 1, dt, ee);
    len_i = 4'(li); len_j = 4'(lj); start = 1'b1;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    while (cyc < dt + 1) begin
      if (poke) begin
        if (cyc == k + 2)      begin start = 1'b1; len_i = 4'd0; len_j = 4'd0; end
        else if (cyc == dt - 1) begin start = 1'b1; len_i = 4'd1; len_j = 4'd1; end
        else                    start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_after_done", int'(busy), 0);
    chk("err_sticky", int'(err), ee);
    chk("pending_events", sq.size() + aq.size() + dq.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_en"}, int'(ram_en), 0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_i_out"}, int'(i_out), 0);
    chk({tag, "_j_out"}, int'(j_out), 0);
    chk({tag, "_step_valid"}, int'(step_valid), 0);
    chk({tag, "_step_dir"}, int'(step_dir), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a read, step or done.
  step_e ms;
  done_e md;
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en) begin
        if (aq.size() == 0) chk("unexpected_ram_en", 1, 0);
        else chk("ram_addr", int'(ram_addr), aq.pop_front());
      end
      if (step_valid) begin
        if (sq.size() == 0) chk("unexpected_step", 1, 0);
        else begin
          ms = sq.pop_front();
          chk("step_dir", int'(step_dir), ms.dir);
          chk("step_i_out", int'(i_out), ms.i);
          chk("step_j_out", int'(j_out), ms.j);
          chk("step_cycle", cyc, ms.t);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          md = dq.pop_front();
          chk("done_cycle", cyc, md.t);
          chk("done_err", int'(err), md.e);
          chk("done_busy", int'(busy), 0);
          chk("done_i_out", int'(i_out), 0);
          chk("done_j_out", int'(j_out), 0);
        end
      end
    end
  end

  initial begin
    int dt, ee, k;
    for (int a = 0; a < 32; a++) mem[a] = 9'd0;
    for (int a = 0; a < 16; a++) begin seq_a[a] = 0; seq_b[a] = 0; end
    rst = 1'b1; start = 1'b0; len_i = 4'd0; len_j = 4'd0;
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Empty traceback, then border-only walk.
    do_op(0, 0, 1'b0);
    do_op(0, 3, 1'b0);
    do_op(4, 0, 1'b0);

    // Identical length-2 sequences: reads 12,6,7,11 then 6,0,1,5, two diag steps.
    build(1'b0);
    seq_a[1] = 0; seq_a[2] = 1; seq_b[1] = 0; seq_b[2] = 1;
    build_fix();
    do_op(2, 2, 1'b0);

    // Up beats left: C=-2, D=0 with mismatch, U=0, L=0.
    for (int a = 0; a < 32; a++) mem[a] = 9'd0;
    seq_a[1] = 0; seq_b[1] = 1;
    mem[1*NP+1] = 9'h1FE;
    do_op(1, 1, 1'b0);

    // Inconsistent cell: C=5 with all neighbours 0 -> err, diag anyway.
    for (int a = 0; a < 32; a++) mem[a] = 9'd0;
    mem[1*NP+1] = 9'd5;
    do_op(1, 1, 1'b0);
    // Next clean start clears err.
    build(1'b0);
    do_op(3, 2, 1'b0);

    // Starts while busy and while in FIN are ignored.
    build(1'b0);
    do_op(2, 1, 1'b1);

    // Reset during the second step's READ abandons the walk.
    build(1'b0);
    seq_a[1] = 0; seq_a[2] = 1; seq_b[1] = 0; seq_b[2] = 1;
    build_fix();
    @(negedge clk);
    run_model(2, 2, cyc + 1, dt, ee);
    len_i = 4'd2; len_j = 4'd2; start = 1'b1;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    while (cyc < k + 7) @(negedge clk);
    rst = 1'b1;
    sq.delete(); aq.delete(); dq.delete();
    @(negedge clk);
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    build(1'b0);
    do_op(1, 1, 1'b0);

    // Randomized matrices and end cells, some with a corrupted cell.
    for (int n = 0; n < 40; n++) begin
      build($urandom_range(0, 3) == 0);
      do_op(int'($urandom_range(0, N)), int'($urandom_range(0, N)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Recompute the matrix from the current seq_a/seq_b without re-randomizing them.
  task automatic build_fix();
    int s, best;
    for (int i = 0; i <= N; i++) nw[i][0] = i * GAP_S;
    for (int j = 0; j <= N; j++) nw[0][j] = j * GAP_S;
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++) begin
        s = (seq_a[i] == seq_b[j]) ? MATCH_S : MISM_S;
        best = nw[i-1][j-1] + s;
        if (nw[i-1][j] + GAP_S > best) best = nw[i-1][j] + GAP_S;
        if (nw[i][j-1] + GAP_S > best) best = nw[i][j-1] + GAP_S;
        nw[i][j] = best;
      end
    for (int i = 0; i <= N; i++)
      for (int j = 0; j <= N; j++) mem[i*NP+j] = 9'(nw[i][j]);
  endtask

endmodule
